// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: datapath-side hazard inputs and pipeline-register controls
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteM, RegWriteW, MemtoRegE;
  logic PCSrcD, PCSrcE, PCSrcM, BranchTakenE;
  logic MemAccessM, mem_ready;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W, RegWriteM, RegWriteW, MemtoRegE,
           PCSrcD, PCSrcE, PCSrcM, BranchTakenE, MemAccessM, mem_ready,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE,
           mem_timeout, stall_cycles
  );
  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W, RegWriteM, RegWriteW, MemtoRegE,
           PCSrcD, PCSrcE, PCSrcM, BranchTakenE, MemAccessM, mem_ready,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE,
           mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding selects, load-use/branch/memory-wait stall and flush sequencing
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state, nextState;
  logic [WAIT_W-1:0] waitCnt;
  logic [CNT_W-1:0] stallCnt;
  logic memTimeout, ldStall, pcWr, memWait;
  logic stallF, stallD, stallE, stallM, flushD, flushE;
  // r15 is the PC and is never forwarded; M wins over W
  function automatic logic [1:0] fwdSel(input logic [3:0] ra, input logic wm, input logic [3:0] am,
                                        input logic ww, input logic [3:0] aw);
    return (ra == 4'd15) ? 2'b00 : (wm && am == ra) ? 2'b10 : (ww && aw == ra) ? 2'b01 : 2'b00;
  endfunction
  assign hz.ForwardAE = fwdSel(hz.RA1E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
  assign hz.ForwardBE = fwdSel(hz.RA2E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
  assign ldStall = hz.MemtoRegE && (hz.WA3E == hz.RA1D || hz.WA3E == hz.RA2D);
  assign pcWr = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;
  assign memWait = hz.MemAccessM && !hz.mem_ready;
  always_comb begin
    nextState = state;
    stallF = 1'b1;
    stallD = 1'b1;
    stallE = 1'b1;
    stallM = 1'b1;
    flushD = 1'b0;
    flushE = 1'b0;
    if (state == MEM_WAIT) begin
      nextState = hz.mem_ready ? RUN : MEM_WAIT;
    end else if (memWait) begin
      nextState = MEM_WAIT;
    end else begin
      stallF = ldStall || pcWr;
      stallD = ldStall;
      stallE = 1'b0;
      stallM = 1'b0;
      flushD = pcWr || hz.BranchTakenE;
      flushE = ldStall || hz.BranchTakenE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      waitCnt <= '0;
      memTimeout <= 1'b0;
      stallCnt <= '0;
    end else begin
      state <= nextState;
      waitCnt <= (state == RUN) ? '0 : (waitCnt == WAIT_W'(MAX_WAIT)) ? waitCnt : waitCnt + 1'b1;
      memTimeout <= memTimeout || (state == MEM_WAIT && waitCnt == WAIT_W'(MAX_WAIT - 1));
      stallCnt <= (stallF && stallCnt != '1) ? stallCnt + 1'b1 : stallCnt;
    end
  end
  assign hz.StallF = stallF;
  assign hz.StallD = stallD;
  assign hz.StallE = stallE;
  assign hz.StallM = stallM;
  assign hz.FlushD = flushD;
  assign hz.FlushE = flushE;
  assign hz.mem_timeout = memTimeout;
  assign hz.stall_cycles = stallCnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors for forwarding, stalls, flushes, memory waits and counters
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;
  pipeline_hazard_ctrl_if #(.CNT_W(4)) hz();
  pipeline_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .hz(hz.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic idle();
    {hz.RA1D, hz.RA2D, hz.RA1E, hz.RA2E, hz.WA3E, hz.WA3M, hz.WA3W} = '0;
    {hz.RegWriteM, hz.RegWriteW, hz.MemtoRegE, hz.PCSrcD, hz.PCSrcE, hz.PCSrcM} = '0;
    {hz.BranchTakenE, hz.MemAccessM, hz.mem_ready} = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulseReset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask
  task automatic loadUse();
    hz.MemtoRegE = 1'b1;
    hz.WA3E = 4'd2;
    hz.RA2D = 4'd2;
  endtask
  initial begin
    idle();
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    check("rst_stallF", hz.StallF, 0);
    check("rst_stallM", hz.StallM, 0);
    check("rst_flushD", hz.FlushD, 0);
    check("rst_timeout", hz.mem_timeout, 0);
    check("rst_count", hz.stall_cycles, 0);
    check("rst_fwdA", hz.ForwardAE, 0);
    hz.RA1E = 4'd3; hz.WA3M = 4'd3; hz.RegWriteM = 1'b1; hz.WA3W = 4'd3; hz.RegWriteW = 1'b1;
    #1 check("fwdA_both", hz.ForwardAE, 2'b10);
    hz.RegWriteM = 1'b0;
    #1 check("fwdA_w", hz.ForwardAE, 2'b01);
    hz.RA1E = 4'd15;
    #1 check("fwdA_r15", hz.ForwardAE, 2'b00);
    hz.RA2E = 4'd5; hz.WA3W = 4'd5;
    #1 check("fwdB_w", hz.ForwardBE, 2'b01);
    hz.RegWriteM = 1'b1; hz.WA3M = 4'd5;
    #1 check("fwdB_m", hz.ForwardBE, 2'b10);
    idle();
    loadUse();
    #1;
    check("lu_stallF", hz.StallF, 1);
    check("lu_stallD", hz.StallD, 1);
    check("lu_flushE", hz.FlushE, 1);
    check("lu_flushD", hz.FlushD, 0);
    check("lu_stallE", hz.StallE, 0);
    step();
    idle();
    #1;
    check("lu_count", hz.stall_cycles, 1);
    check("lu_release", hz.StallF, 0);
    check("lu_release_flushE", hz.FlushE, 0);
    loadUse();
    hz.BranchTakenE = 1'b1;
    #1;
    check("br_flushD", hz.FlushD, 1);
    check("br_flushE", hz.FlushE, 1);
    check("br_stallD", hz.StallD, 1);
    idle();
    hz.PCSrcD = 1'b1;
    #1;
    check("pc_stallF", hz.StallF, 1);
    check("pc_flushD", hz.FlushD, 1);
    check("pc_stallD", hz.StallD, 0);
    check("pc_flushE", hz.FlushE, 0);
    idle();
    pulseReset();
    hz.MemAccessM = 1'b1;
    loadUse();
    #1;
    check("mw_first_stallM", hz.StallM, 1);
    check("mw_first_stallE", hz.StallE, 1);
    check("mw_first_flushE", hz.FlushE, 0);
    step();
    hz.MemtoRegE = 1'b0;
    #1 check("mw_wait1", hz.StallE, 1);
    step();
    check("mw_wait2", hz.StallF, 1);
    step();
    hz.mem_ready = 1'b1;
    #1;
    check("mw_ready_stallM", hz.StallM, 1);
    check("mw_ready_flushD", hz.FlushD, 0);
    step();
    idle();
    #1;
    check("mw_back_stallF", hz.StallF, 0);
    check("mw_back_stallM", hz.StallM, 0);
    check("mw_count", hz.stall_cycles, 4);
    pulseReset();
    hz.MemAccessM = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 4) check("to_before", hz.mem_timeout, 0);
      if (i == 5) check("to_rise", hz.mem_timeout, 1);
    end
    check("to_count", hz.stall_cycles, 10);
    hz.mem_ready = 1'b1;
    step();
    idle();
    #1;
    check("to_sticky", hz.mem_timeout, 1);
    check("to_run", hz.StallE, 0);
    check("to_count11", hz.stall_cycles, 11);
    hz.PCSrcD = 1'b1;
    repeat (4) step();
    check("sat_reach", hz.stall_cycles, 15);
    repeat (3) step();
    check("sat_hold", hz.stall_cycles, 15);
    idle();
    pulseReset();
    hz.MemAccessM = 1'b1;
    repeat (6) step();
    check("mid_timeout_pre", hz.mem_timeout, 1);
    hz.mem_ready = 1'b1;
    #1 check("mid_stall_pre", hz.StallM, 1);
    rst_n = 1'b0;
    #1;
    check("mid_stallF", hz.StallF, 0);
    check("mid_stallM", hz.StallM, 0);
    check("mid_timeout", hz.mem_timeout, 0);
    check("mid_count", hz.stall_cycles, 0);
    rst_n = 1'b1;
    idle();
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
